// File: rtl/vga_sync_decoder.sv
// Receive-side VGA timing checker: measures hsync/vsync periods, locks onto the
// configured mode and recovers per-pixel coordinates and colour data.
module vga_sync_decoder #(
    parameter int H_SYNC      = 128,
    parameter int H_START     = 216,
    parameter int H_ACTIVE    = 800,
    parameter int H_TOTAL     = 1056,
    parameter int V_START     = 27,
    parameter int V_ACTIVE    = 600,
    parameter int V_TOTAL     = 628,
    parameter int LOCK_FRAMES = 2
) (
    input  logic        pclk,
    input  logic        reset,
    input  logic        hsync,
    input  logic        vsync,
    input  logic [3:0]  vga_r,
    input  logic [3:0]  vga_g,
    input  logic [3:0]  vga_b,
    output logic        locked,
    output logic        px_valid,
    output logic [10:0] px_x,
    output logic [10:0] px_y,
    output logic [11:0] px_data,
    output logic        frame_start,
    output logic        err,
    output logic [10:0] h_total_meas,
    output logic [10:0] v_total_meas
);

    localparam logic [10:0] CNT_MAX = 11'd2047;

    typedef enum logic [1:0] {SEARCH, CHECK, LOCKED} state_t;

    state_t      state_reg, state_next;
    logic        s_h_reg, s_v_reg, p_h_reg, p_v_reg;
    logic [11:0] s_rgb_reg;
    logic [10:0] hc_reg, vc_reg;
    logic [3:0]  good_reg, good_next;
    logic        dirty_reg, dirty_next;
    logic        err_next;

    logic        fall_h, rise_h, fall_v;
    logic [11:0] hc_inc, vc_inc;
    logic [10:0] hc_sat, vc_sat, pos_h, pos_v;
    logic        v_hlen, v_hsync, v_vlen, v_vnoh, timeout, viol;
    logic        h_act, v_act, valid_next, fs_next;
    logic [10:0] x_next, y_next;
    logic [11:0] data_next;

    // Stage 1: pin capture plus the previous sync levels for edge detection
    always_ff @(posedge pclk) begin
        if (reset) begin
            s_h_reg   <= 1'b1;
            s_v_reg   <= 1'b1;
            p_h_reg   <= 1'b1;
            p_v_reg   <= 1'b1;
            s_rgb_reg <= '0;
        end else begin
            s_h_reg   <= hsync;
            s_v_reg   <= vsync;
            p_h_reg   <= s_h_reg;
            p_v_reg   <= s_v_reg;
            s_rgb_reg <= {vga_r, vga_g, vga_b};
        end
    end

    always_comb begin
        fall_h  = p_h_reg & ~s_h_reg;
        rise_h  = ~p_h_reg & s_h_reg;
        fall_v  = p_v_reg & ~s_v_reg;
        hc_inc  = {1'b0, hc_reg} + 12'd1;
        vc_inc  = {1'b0, vc_reg} + 12'd1;
        hc_sat  = (hc_reg == CNT_MAX) ? CNT_MAX : hc_inc[10:0];
        vc_sat  = (vc_reg == CNT_MAX) ? CNT_MAX : vc_inc[10:0];
        pos_h   = fall_h ? 11'd0 : hc_sat;
        pos_v   = fall_v ? 11'd0 : (fall_h ? vc_sat : vc_reg);
        v_hlen  = fall_h & (hc_inc != 12'(H_TOTAL));
        v_hsync = rise_h & (pos_h != 11'(H_SYNC));
        v_vlen  = fall_v & (vc_inc != 12'(V_TOTAL));
        v_vnoh  = fall_v & ~fall_h;
        timeout = (pos_h == CNT_MAX) | (pos_v == CNT_MAX);
        viol    = v_hlen | v_hsync | v_vlen | v_vnoh | timeout;
    end

    // Lock FSM: dirty remembers a violation inside the frame still in progress
    always_comb begin
        state_next = state_reg;
        good_next  = good_reg;
        dirty_next = dirty_reg;
        err_next   = 1'b0;
        case (state_reg)
            SEARCH: begin
                if (fall_v) begin
                    state_next = CHECK;
                    good_next  = 4'd0;
                    dirty_next = 1'b0;
                end
            end
            CHECK: begin
                err_next = viol;
                if (timeout) begin
                    state_next = SEARCH;
                end else begin
                    if (viol) begin
                        good_next  = 4'd0;
                        dirty_next = 1'b1;
                    end
                    if (fall_v) begin
                        good_next  = (!dirty_reg && !viol) ? good_reg + 4'd1 : 4'd0;
                        dirty_next = 1'b0;
                    end
                    if (good_next == 4'(LOCK_FRAMES))
                        state_next = LOCKED;
                end
            end
            LOCKED: begin
                err_next = viol;
                if (timeout) begin
                    state_next = SEARCH;
                end else if (viol) begin
                    state_next = CHECK;
                    good_next  = 4'd0;
                    dirty_next = 1'b1;
                end
            end
            default: state_next = SEARCH;
        endcase
    end

    always_comb begin
        h_act      = ({1'b0, pos_h} >= 12'(H_START)) && ({1'b0, pos_h} < 12'(H_START + H_ACTIVE));
        v_act      = ({1'b0, pos_v} >= 12'(V_START)) && ({1'b0, pos_v} < 12'(V_START + V_ACTIVE));
        valid_next = (state_next == LOCKED) && h_act && v_act;
        x_next     = valid_next ? pos_h - 11'(H_START) : 11'd0;
        y_next     = valid_next ? pos_v - 11'(V_START) : 11'd0;
        data_next  = valid_next ? s_rgb_reg : 12'd0;
        fs_next    = valid_next && (x_next == 11'd0) && (y_next == 11'd0);
    end

    // Stage 2: counters, FSM state and registered pixel outputs
    always_ff @(posedge pclk) begin
        if (reset) begin
            state_reg    <= SEARCH;
            good_reg     <= 4'd0;
            dirty_reg    <= 1'b0;
            hc_reg       <= 11'd0;
            vc_reg       <= 11'd0;
            px_valid     <= 1'b0;
            px_x         <= 11'd0;
            px_y         <= 11'd0;
            px_data      <= 12'd0;
            frame_start  <= 1'b0;
            err          <= 1'b0;
            h_total_meas <= 11'd0;
            v_total_meas <= 11'd0;
        end else begin
            state_reg   <= state_next;
            good_reg    <= good_next;
            dirty_reg   <= dirty_next;
            hc_reg      <= pos_h;
            vc_reg      <= pos_v;
            px_valid    <= valid_next;
            px_x        <= x_next;
            px_y        <= y_next;
            px_data     <= data_next;
            frame_start <= fs_next;
            err         <= err_next;
            if (fall_h)
                h_total_meas <= hc_sat;
            if (fall_v)
                v_total_meas <= vc_sat;
        end
    end

    assign locked = (state_reg == LOCKED);

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Directed bench for vga_sync_decoder on a scaled-down video mode; a scoreboard
// queue holds the expected stage-2 outputs for every driven pixel clock.
module tb_vga_sync_decoder;

    localparam int T_H_SYNC   = 6;
    localparam int T_H_START  = 10;
    localparam int T_H_ACTIVE = 24;
    localparam int T_H_TOTAL  = 40;
    localparam int T_V_START  = 3;
    localparam int T_V_ACTIVE = 8;
    localparam int T_V_TOTAL  = 12;
    localparam int T_VSW      = 2;
    localparam int T_LOCK     = 2;

    logic        pclk = 1'b0;
    logic        reset = 1'b1;
    logic        hsync = 1'b1;
    logic        vsync = 1'b1;
    logic [3:0]  vga_r = 4'd0, vga_g = 4'd0, vga_b = 4'd0;
    logic        locked, px_valid, frame_start, err;
    logic [10:0] px_x, px_y, h_total_meas, v_total_meas;
    logic [11:0] px_data;

    always #5 pclk = ~pclk;

    vga_sync_decoder #(
        .H_SYNC(T_H_SYNC), .H_START(T_H_START), .H_ACTIVE(T_H_ACTIVE), .H_TOTAL(T_H_TOTAL),
        .V_START(T_V_START), .V_ACTIVE(T_V_ACTIVE), .V_TOTAL(T_V_TOTAL), .LOCK_FRAMES(T_LOCK)
    ) dut (
        .pclk(pclk), .reset(reset), .hsync(hsync), .vsync(vsync),
        .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
        .locked(locked), .px_valid(px_valid), .px_x(px_x), .px_y(px_y),
        .px_data(px_data), .frame_start(frame_start), .err(err),
        .h_total_meas(h_total_meas), .v_total_meas(v_total_meas)
    );

    typedef struct packed {
        logic        lk;
        logic        valid;
        logic        fs;
        logic        er;
        logic [10:0] x;
        logic [10:0] y;
        logic [11:0] data;
    } exp_t;

    exp_t        sb_q[$];
    int          checks = 0;
    int          fails = 0;
    bit          lk = 1'b0;
    int          n_valid, n_fs;
    logic [10:0] last_x, last_y;

    task automatic check(string tag, logic [37:0] obs, logic [37:0] want);
        checks++;
        assert (obs === want) else begin
            fails++;
            $error("FAIL %s: observed %h required %h", tag, obs, want);
        end
    endtask

    function automatic exp_t model(int c, int l, logic [11:0] rgb, bit e_err);
        exp_t m;
        m    = '0;
        m.lk = lk;
        m.er = e_err;
        if (lk && c >= T_H_START && c < T_H_START + T_H_ACTIVE &&
            l >= T_V_START && l < T_V_START + T_V_ACTIVE) begin
            m.valid = 1'b1;
            m.x     = 11'(c - T_H_START);
            m.y     = 11'(l - T_V_START);
            m.data  = rgb;
            m.fs    = (c == T_H_START) && (l == T_V_START);
        end
        return m;
    endfunction

    // One pclk: drive pins, queue their expected result, compare the entry now due
    task automatic step(logic h, logic v, logic [11:0] rgb, exp_t e);
        exp_t w;
        hsync = h;
        vsync = v;
        {vga_r, vga_g, vga_b} = rgb;
        sb_q.push_back(e);
        @(posedge pclk);
        #1;
        if (sb_q.size() >= 2) begin
            w = sb_q.pop_front();
            check("px", {locked, px_valid, frame_start, err, px_x, px_y, px_data}, w);
        end
        if (px_valid) begin
            n_valid++;
            last_x = px_x;
            last_y = px_y;
        end
        if (frame_start) n_fs++;
    endtask

    task automatic line(int l, int c0, int len, int hs_low, int err_at, bit gain);
        logic [10:0] xv, yv;
        logic [11:0] rgb;
        exp_t        e;
        for (int c = c0; c < len; c++) begin
            if (gain && c == 0) lk = 1'b1;
            if (c == err_at) lk = 1'b0;
            xv  = 11'(c - T_H_START);
            yv  = 11'(l - T_V_START);
            rgb = {xv[3:0], yv[3:0], 4'h5};
            e   = model(c, l, rgb, c == err_at);
            step(c >= hs_low, !(l < T_VSW), rgb, e);
        end
    endtask

    task automatic frame(bit gain, int sp_line, int sp_len, int sp_hs,
                         int err_line, int err_at, int first_l, int last_l);
        for (int l = first_l; l <= last_l; l++)
            line(l, 0, (l == sp_line) ? sp_len : T_H_TOTAL, (l == sp_line) ? sp_hs : T_H_SYNC,
                 (l == err_line) ? err_at : -1, gain && l == 0);
    endtask

    task automatic clean(bit gain);
        frame(gain, -1, 0, 0, -1, 0, 0, T_V_TOTAL - 1);
    endtask

    task automatic stats_clear();
        n_valid = 0;
        n_fs    = 0;
        last_x  = 11'd0;
        last_y  = 11'd0;
    endtask

    task automatic stats_check(string tag);
        check({tag, "_nvalid"}, 38'(n_valid), 38'(T_H_ACTIVE * T_V_ACTIVE));
        check({tag, "_nfs"}, 38'(n_fs), 38'd1);
        check({tag, "_last"}, {16'd0, last_x, last_y}, {16'd0, 11'(T_H_ACTIVE - 1), 11'(T_V_ACTIVE - 1)});
    endtask

    task automatic rst_step();
        reset = 1'b1;
        hsync = 1'b1;
        vsync = 1'b1;
        lk    = 1'b0;
        sb_q.delete();
        sb_q.push_back('0);
        @(posedge pclk);
        #1;
        check("rst_out", {locked, px_valid, frame_start, err, px_x, px_y, px_data}, 38'd0);
        check("rst_meas", {16'd0, h_total_meas, v_total_meas}, 38'd0);
        reset = 1'b0;
    endtask

    initial begin
        stats_clear();
        rst_step();
        rst_step();
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 12'd0, '0);

        // Ideal stream: lock on the third vsync fall
        clean(1'b0);
        check("h_meas_f0", 38'(h_total_meas), 38'(T_H_TOTAL));
        clean(1'b0);
        check("v_meas_f1", 38'(v_total_meas), 38'(T_V_TOTAL));
        check("unlocked_f1", 38'(locked), 38'd0);
        stats_clear();
        clean(1'b1);
        stats_check("f2");
        check("locked_f2", 38'(locked), 38'd1);
        stats_clear();
        clean(1'b0);
        stats_check("f3");

        // Short line while locked
        frame(1'b0, 5, T_H_TOTAL - 1, T_H_SYNC, -1, 0, 0, 5);
        line(6, 0, 2, T_H_SYNC, 0, 1'b0);
        check("h_meas_glitch", 38'(h_total_meas), 38'(T_H_TOTAL - 1));
        check("unlocked_glitch", 38'(locked), 38'd0);
        line(6, 2, T_H_TOTAL, T_H_SYNC, -1, 1'b0);
        frame(1'b0, -1, 0, 0, -1, 0, 7, T_V_TOTAL - 1);
        clean(1'b0);
        clean(1'b0);

        // Relock, then a narrow hsync pulse
        frame(1'b1, -1, 0, 0, -1, 0, 0, 2);
        check("relock_f7", 38'(locked), 38'd1);
        frame(1'b0, 3, T_H_TOTAL, T_H_SYNC - 1, 3, T_H_SYNC - 1, 3, T_V_TOTAL - 1);
        check("unlocked_sync", 38'(locked), 38'd0);
        clean(1'b0);
        clean(1'b0);

        // Loss of signal: hsync stuck high until the counter times out
        frame(1'b1, 4, T_H_TOTAL + 2100, T_H_SYNC, 4, 2047, 0, 4);
        check("unlocked_los", 38'(locked), 38'd0);
        stats_clear();
        clean(1'b0);
        check("no_valid_los", 38'(n_valid), 38'd0);
        clean(1'b0);

        // Reset in the middle of a locked frame
        frame(1'b1, -1, 0, 0, -1, 0, 0, 5);
        check("locked_f13", 38'(locked), 38'd1);
        line(6, 0, 20, T_H_SYNC, -1, 1'b0);
        rst_step();
        line(6, 21, T_H_TOTAL, T_H_SYNC, -1, 1'b0);
        frame(1'b0, -1, 0, 0, -1, 0, 7, T_V_TOTAL - 1);
        clean(1'b0);
        clean(1'b0);
        check("unlocked_after_rst", 38'(locked), 38'd0);
        stats_clear();
        clean(1'b1);
        stats_check("f16");
        check("locked_f16", 38'(locked), 38'd1);
        step(1'b1, 1'b1, 12'd0, model(0, 0, 12'd0, 1'b0));

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule

// File: doc/vga_sync_decoder.md
# vga_sync_decoder

Receive-side counterpart of the 800x600@60 VGA timing generator. It samples an incoming hsync/vsync/RGB444 stream in the pixel clock domain, measures line and frame lengths, and locks once the timing matches the configured mode. When locked it recovers per-pixel coordinates and data. It is used as a loopback checker and capture front end for the display path.

## Interface
- H_SYNC, 128: hsync low width in pclk cycles
- H_START, 216: cycles from first hsync-low sample to first active pixel
- H_ACTIVE, 800: active pixels per line
- H_TOTAL, 1056: pclk cycles per line
- V_START, 27: lines from first vsync-low line to first active line
- V_ACTIVE, 600: active lines per frame
- V_TOTAL, 628: lines per frame
- LOCK_FRAMES, 2: consecutive clean complete frames required to lock (1..15)
- pclk  in  1  pixel clock; the block's only clock
- reset  in  1  synchronous, active-high reset
- hsync  in  1  horizontal sync, active low
- vsync  in  1  vertical sync, active low, falls on the same pclk as hsync
- vga_r, vga_g, vga_b  in  4 each  pixel colour
- locked  out  1  timing matches the mode
- px_valid  out  1  px_* carry an active pixel
- px_x  out  11  column 0..H_ACTIVE-1 (0 when !px_valid)
- px_y  out  11  row 0..V_ACTIVE-1 (0 when !px_valid)
- px_data  out  12  {r,g,b} of the pixel (0 when !px_valid)
- frame_start  out  1  one-cycle pulse with pixel (0,0)
- err  out  1  one-cycle pulse on any timing violation
- h_total_meas  out  11  length of the last completed line
- v_total_meas  out  11  line count of the last completed frame

## Operation
- Stage 1 registers the pins into s_h, s_v, s_rgb, with prior copies p_h and p_v.
- Edge detection: fall_h = p_h & ~s_h, rise_h = ~p_h & s_h, fall_v = p_v & ~s_v.
- Horizontal position of the stage-1 sample: pos_h = fall_h ? 0 : hc+1. Register hc <= pos_h; it saturates at 2047.
- Vertical position: pos_v = fall_v ? 0 : (fall_h ? vc+1 : vc). Register vc <= pos_v; it saturates at 2047.
- On fall_h, h_total_meas <= hc+1. On fall_v, v_total_meas <= vc+1. Both update in every state.
- Violations, checked only in CHECK and LOCKED:
  - fall_h with hc+1 != H_TOTAL
  - rise_h with pos_h != H_SYNC
  - fall_v with vc+1 != V_TOTAL
  - fall_v without fall_h in the same cycle
  - hc or vc reaching 2047 (timeout)
- FSM states:
  - SEARCH: on fall_v -> CHECK, good_cnt=0, dirty=0.
  - CHECK: on a violation, good_cnt=0 and dirty=1; a timeout goes to SEARCH instead. On fall_v, if !dirty and no violation this cycle, good_cnt+1, otherwise good_cnt=0. dirty clears on fall_v. When good_cnt reaches LOCK_FRAMES -> LOCKED.
  - LOCKED: a violation -> CHECK (good_cnt=0, dirty=1); a timeout -> SEARCH.
- err pulses for every violation in CHECK and LOCKED. SEARCH never raises err.
- Stage 2 output registers:
  - px_valid <= LOCKED & H_START<=pos_h<H_START+H_ACTIVE & V_START<=pos_v<V_START+V_ACTIVE
  - px_x = pos_h-H_START, px_y = pos_v-V_START, px_data = s_rgb, all forced to 0 when not valid
  - frame_start <= px_valid_next & px_x_next==0 & px_y_next==0
- Simultaneous fall_h and fall_v is the normal frame boundary: both length checks run and vc restarts at 0.

## Timing
- Reset: locked, px_valid, px_x, px_y, px_data, frame_start, err, h_total_meas and v_total_meas all 0. State SEARCH, hc=vc=0, s_h=s_v=p_h=p_v=1, s_rgb=0.
- Latency: a pin value sampled at edge k appears on px_* at edge k+1. Pin-to-output latency is 2 pclk.
- locked and err change in the same cycle as the stage-2 outputs derived from the triggering edge.
- Reset asserted mid-frame returns to SEARCH the next cycle. Outputs are 0 until relock, at least LOCK_FRAMES+1 frame boundaries later.

## Test plan
- Ideal stream: drive 4 frames of 1056x628 timing with hsync low for 128 cycles and vsync low for 4 lines. Required: h_total_meas=1056, v_total_meas=628, locked=1 at the 3rd fall_v, exactly 480000 px_valid cycles per locked frame, and zero err.
- Pixel mapping: pattern rgb = {x[3:0], y[3:0], 4'h5}. In a locked frame, require px_data to match px_x/px_y, frame_start exactly once per frame, and last pixel (799,599).
- Line-length glitch: one line of 1055 cycles while locked. Required: err pulse, locked=0, h_total_meas=1055, then relock after 2 clean frames.
- Sync width: hsync low for 127 cycles while locked. Required: err at rise_h and drop to CHECK.
- Loss of signal: hold hsync high for 2100 cycles. Required: err pulse at hc=2047, SEARCH state, locked=0, and px_valid=0 afterwards.
- Reset mid-frame: assert reset at line 300 while locked. Required: all outputs 0 the next cycle, and locked only after the 3rd subsequent fall_v.
